// File: rtl/tpu_pkg.sv
// Shared types and widths for the TPU MAC datapath.
//   MAC_A_W / MAC_C_W / MAC_DT_W : operand, accumulator and data-type widths
//   arb_state_e                  : MAC arbiter power/issue state
//   mac_op_t                     : one operand set as presented to the MAC
package tpu_pkg;

  localparam int unsigned MAC_A_W  = 16;
  localparam int unsigned MAC_C_W  = 32;
  localparam int unsigned MAC_DT_W = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAKE = 2'd1,
    ARB_RUN  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [MAC_DT_W-1:0] dt;
    logic [MAC_A_W-1:0]  a;
    logic [MAC_A_W-1:0]  b;
    logic [MAC_C_W-1:0]  c;
  } mac_op_t;

endpackage

// File: rtl/tpu_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each in-flight MAC op.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : enqueue a tag (ignored when full)
//   pop, rdata    : dequeue the head tag (ignored when empty); rdata is the head
//   count         : occupancy, 0..DEPTH
//   empty, full   : occupancy flags
module tpu_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tpu_mac_arbiter.sv
// Round-robin arbiter sharing one MAC unit between NUM_REQ requesters.
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready              : per-requester handshake (ready is one-hot, combinational)
//   req_data_type/req_a/req_b/req_c  : per-requester operand sets, concatenated by index
//   rsp_valid/rsp_result             : one-cycle response pulse routed to the issuing requester
//   mac_*                            : registered operands/enable to the MAC, result/ready from it
//   busy, outstanding, err_orphan    : status; err_orphan is sticky until reset
module tpu_mac_arbiter
  import tpu_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned TAG_DEPTH    = 8,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3*NUM_REQ-1:0]          req_data_type,
  input  logic [16*NUM_REQ-1:0]         req_a,
  input  logic [16*NUM_REQ-1:0]         req_b,
  input  logic [32*NUM_REQ-1:0]         req_c,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [31:0]                   rsp_result,
  output logic                          mac_enable,
  output logic [2:0]                    mac_data_type,
  output logic [15:0]                   mac_a,
  output logic [15:0]                   mac_b,
  output logic [31:0]                   mac_c,
  output logic                          mac_valid_in,
  input  logic [31:0]                   mac_result,
  input  logic                          mac_valid_out,
  input  logic                          mac_ready,
  output logic                          busy,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic                          err_orphan
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W  = $clog2(TAG_DEPTH) + 1;
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [IDX_W-1:0]    rr_ptr_q;
  mac_op_t             op_q;
  logic                mac_valid_in_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [MAC_C_W-1:0]  rsp_result_q;
  logic                err_orphan_q;

  mac_op_t             req_op_c [NUM_REQ];
  logic [NUM_REQ-1:0]  grant_c;
  logic [IDX_W-1:0]    grant_idx_c;
  logic [IDX_W-1:0]    cand_c;
  logic                found_c;
  logic                can_issue_c;
  logic                transfer_c;
  logic                idle_cycle_c;
  logic [NUM_REQ-1:0]  rsp_onehot_c;

  logic [IDX_W-1:0]    tag_head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                fifo_full;

  // Unpack the flat per-requester buses into operand structs.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_op_c[i] = '{dt: req_data_type[MAC_DT_W*i +: MAC_DT_W],
                      a:  req_a[MAC_A_W*i +: MAC_A_W],
                      b:  req_b[MAC_A_W*i +: MAC_A_W],
                      c:  req_c[MAC_C_W*i +: MAC_C_W]};
    end
  end

  // A full FIFO blocks issue even when a pop lands in the same cycle.
  assign can_issue_c = mac_ready && !fifo_full;

  // Round-robin pick: first valid requester after the last granted one.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = rr_ptr_q;
    cand_c      = '0;
    found_c     = 1'b0;
    if (state_q == ARB_RUN && can_issue_c) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand_c = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
        if (!found_c && req_valid[cand_c]) begin
          found_c     = 1'b1;
          grant_idx_c = cand_c;
        end
      end
    end
    if (found_c) grant_c[grant_idx_c] = 1'b1;
  end

  assign transfer_c   = |grant_c;
  assign idle_cycle_c = !(|req_valid) && (fifo_count == '0);

  // Next state and idle countdown; the counter only runs in RUN.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    case (state_q)
      ARB_IDLE: if (|req_valid) state_d = ARB_WAKE;
      ARB_WAKE: state_d = ARB_RUN;
      ARB_RUN: begin
        if (idle_cycle_c) begin
          if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) state_d = ARB_IDLE;
          else idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    rsp_onehot_c           = '0;
    rsp_onehot_c[tag_head] = 1'b1;
  end

  // Issue registers, RR pointer and response steering.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= IDX_W'(NUM_REQ - 1);
      op_q           <= '0;
      mac_valid_in_q <= 1'b0;
      rsp_valid_q    <= '0;
      rsp_result_q   <= '0;
      err_orphan_q   <= 1'b0;
    end else begin
      mac_valid_in_q <= transfer_c;
      if (transfer_c) begin
        op_q     <= req_op_c[grant_idx_c];
        rr_ptr_q <= grant_idx_c;
      end
      rsp_valid_q <= '0;
      if (mac_valid_out) begin
        if (fifo_empty) begin
          err_orphan_q <= 1'b1;
        end else begin
          rsp_valid_q  <= rsp_onehot_c;
          rsp_result_q <= mac_result;
        end
      end
    end
  end

  tpu_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (transfer_c),
    .wdata (grant_idx_c),
    .pop   (mac_valid_out),
    .rdata (tag_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign req_ready     = grant_c;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign mac_enable    = (state_q != ARB_IDLE);
  assign mac_data_type = op_q.dt;
  assign mac_a         = op_q.a;
  assign mac_b         = op_q.b;
  assign mac_c         = op_q.c;
  assign mac_valid_in  = mac_valid_in_q;
  assign busy          = (state_q != ARB_IDLE) || (fifo_count != '0);
  assign outstanding   = fifo_count;
  assign err_orphan    = err_orphan_q;

endmodule

// File: tb/tb_tpu_mac_arbiter.sv
// Directed bench for tpu_mac_arbiter with a behavioural MAC and a response scoreboard.
module tb_tpu_mac_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned TD = 8;
  localparam int unsigned IT = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [3*NR-1:0] req_data_type = '0;
  logic [16*NR-1:0] req_a = '0;
  logic [16*NR-1:0] req_b = '0;
  logic [32*NR-1:0] req_c = '0;
  logic [NR-1:0]   rsp_valid;
  logic [31:0]     rsp_result;
  logic            mac_enable;
  logic [2:0]      mac_data_type;
  logic [15:0]     mac_a;
  logic [15:0]     mac_b;
  logic [31:0]     mac_c;
  logic            mac_valid_in;
  logic [31:0]     mac_result = '0;
  logic            mac_valid_out = 1'b0;
  logic            mac_ready = 1'b1;
  logic            busy;
  logic [$clog2(TD):0] outstanding;
  logic            err_orphan;

  always #5 clk = ~clk;

  tpu_mac_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD), .IDLE_TIMEOUT(IT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data_type(req_data_type),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .mac_enable(mac_enable), .mac_data_type(mac_data_type),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_valid_in(mac_valid_in),
    .mac_result(mac_result), .mac_valid_out(mac_valid_out), .mac_ready(mac_ready),
    .busy(busy), .outstanding(outstanding), .err_orphan(err_orphan)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural MAC: result = a*b+c, fixed latency, releases limited by pop_budget.
  typedef struct { logic [31:0] r; int due; } mres_t;
  mres_t mq[$];
  int    cyc = 0;
  int    mac_lat = 3;
  int    pop_budget = 1 << 30;

  initial begin
    mres_t h;
    forever begin
      @(posedge clk); #1;
      cyc++;
      mac_valid_out = 1'b0;
      if (mq.size() > 0 && pop_budget > 0 && mq[0].due <= cyc) begin
        h = mq.pop_front();
        pop_budget--;
        mac_valid_out = 1'b1;
        mac_result = h.r;
      end
      if (mac_valid_in)
        mq.push_back('{r: 32'(mac_a) * 32'(mac_b) + mac_c, due: cyc + mac_lat});
    end
  end

  // Scoreboard: transfers push the expected result, responses pop and compare.
  typedef struct { int idx; logic [31:0] r; } exp_t;
  exp_t sb[$];
  int   grant_log[$];
  int   grant_cyc[$];

  always @(negedge clk) begin
    exp_t e;
    logic [NR-1:0] oh;
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e  = sb.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk("rsp_route", 64'(rsp_valid), 64'(oh));
          chk("rsp_value", 64'(rsp_result), 64'(e.r));
        end
      end
      for (int i = 0; i < int'(NR); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{idx: i,
                         r: 32'(req_a[16*i +: 16]) * 32'(req_b[16*i +: 16]) + req_c[32*i +: 32]});
          grant_log.push_back(i);
          grant_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input int i, input logic [2:0] dt, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] c);
    req_data_type[3*i +: 3] = dt;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_c[32*i +: 32] = c;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    logic done;
    done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      tick(1);
      if (outstanding == '0 && sb.size() == 0 && mq.size() == 0) done = 1'b1;
    end
    chk(tag, 64'(done), 64'(1));
  endtask

  task automatic wait_rsp(input string tag, input int i, input logic [31:0] exp);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick(1);
      if (rsp_valid[i]) seen = 1'b1;
    end
    chk({tag, "_seen"}, 64'(seen), 64'(1));
    chk({tag, "_value"}, 64'(rsp_result), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    // ---- reset state
    tick(2); rst = 1'b0; tick(1);
    chk("rst_enable", 64'(mac_enable), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp", 64'(rsp_valid), 64'(0));
    chk("rst_orphan", 64'(err_orphan), 64'(0));
    chk("rst_valid_in", 64'(mac_valid_in), 64'(0));

    // ---- single requester through IDLE -> WAKE -> RUN
    set_req(0, 3'd0, 16'd10, 16'd20, 32'd5);
    req_valid = 4'b0001;
    @(negedge clk); chk("idle_noready", 64'(req_ready), 64'(0));
    @(posedge clk); #1; chk("wake_enable", 64'(mac_enable), 64'(1));
    @(negedge clk); chk("wake_noready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk); chk("run_grant0", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1; req_valid = '0;
    chk("issue_valid", 64'(mac_valid_in), 64'(1));
    chk("issue_a", 64'(mac_a), 64'(10));
    chk("issue_b", 64'(mac_b), 64'(20));
    chk("issue_c", 64'(mac_c), 64'(5));
    chk("issue_outst", 64'(outstanding), 64'(1));
    tick(1);
    chk("issue_pulse", 64'(mac_valid_in), 64'(0));
    chk("issue_hold_a", 64'(mac_a), 64'(10));
    wait_rsp("single", 0, 32'd205);
    wait_drain("single_drain", 20);

    // ---- four requesters, continuous round robin from reset pointer
    rst = 1'b1; tick(2); rst = 1'b0;
    grant_log.delete(); grant_cyc.delete();
    set_req(0, 3'd1, 16'd1, 16'd2, 32'd3);
    set_req(1, 3'd2, 16'd4, 16'd5, 32'd6);
    set_req(2, 3'd3, 16'd7, 16'd8, 32'd100);
    set_req(3, 3'd4, 16'd9, 16'd10, 32'd11);
    req_valid = 4'b1111;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (grant_log.size() >= 12) ok = 1'b1;
    end
    @(posedge clk); #1; req_valid = '0;
    chk("rr_reached12", 64'(ok), 64'(1));
    if (grant_log.size() >= 12) begin
      for (int k = 0; k < 12; k++) chk("rr_order", 64'(grant_log[k]), 64'(k % 4));
      chk("rr_back_to_back", 64'(grant_cyc[11] - grant_cyc[0]), 64'(11));
    end
    wait_drain("rr_drain", 40);

    // ---- FIFO full: no grant until after a pop, none in the pop cycle
    pop_budget = 0;
    req_valid = 4'b0001;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      tick(1);
      if (outstanding == 4'(TD)) ok = 1'b1;
    end
    chk("full_reached", 64'(ok), 64'(1));
    @(negedge clk); chk("full_noready", 64'(req_ready), 64'(0));
    pop_budget = 1;
    @(negedge clk);
    chk("full_pop_cycle_valid_out", 64'(mac_valid_out), 64'(1));
    chk("full_pop_noready", 64'(req_ready), 64'(0));
    @(negedge clk);
    chk("after_pop_outst", 64'(outstanding), 64'(TD - 1));
    chk("after_pop_grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1; req_valid = '0;
    chk("refill_outst", 64'(outstanding), 64'(TD));
    pop_budget = 1 << 30;
    wait_drain("full_drain", 60);

    // ---- mac_ready low stalls issue; resumes after pointer (last grant was 0)
    mac_ready = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk("stall_noready", 64'(req_ready), 64'(0));
      @(posedge clk); #1; chk("stall_no_issue", 64'(mac_valid_in), 64'(0));
    end
    mac_ready = 1'b1;
    @(negedge clk); chk("stall_resume", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1; req_valid = '0;
    chk("stall_issue_a", 64'(mac_a), 64'(4));

    // ---- idle timeout after the last response, then a fresh wake-up
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      tick(1);
      if (outstanding == '0) ok = 1'b1;
    end
    chk("idle_drained", 64'(ok), 64'(1));
    tick(IT - 1);
    chk("idle_still_on", 64'(mac_enable), 64'(1));
    tick(1);
    chk("idle_off", 64'(mac_enable), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    set_req(3, 3'd0, 16'd0, 16'd999, 32'd42);
    req_valid = 4'b1000;
    @(negedge clk); chk("rewake_idle_noready", 64'(req_ready), 64'(0));
    @(posedge clk); #1; chk("rewake_enable", 64'(mac_enable), 64'(1));
    @(negedge clk); chk("rewake_noready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk); chk("rewake_grant3", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1; req_valid = '0;
    wait_rsp("rewake", 3, 32'd42);

    // ---- reset with three ops in flight: results become orphans
    pop_budget = 0;
    req_valid = 4'b0001;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick(1);
      if (outstanding == 4'd3) begin ok = 1'b1; req_valid = '0; end
    end
    req_valid = '0;
    chk("orphan_setup", 64'(ok), 64'(1));
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("orphan_rst_outst", 64'(outstanding), 64'(0));
    chk("orphan_rst_err", 64'(err_orphan), 64'(0));
    chk("orphan_rst_busy", 64'(busy), 64'(0));
    pop_budget = 1 << 30;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("orphan_no_rsp", 64'(rsp_valid), 64'(0));
    end
    chk("orphan_mq_empty", 64'(mq.size()), 64'(0));
    chk("orphan_err_set", 64'(err_orphan), 64'(1));
    chk("orphan_outst", 64'(outstanding), 64'(0));
    tick(3);
    chk("orphan_sticky", 64'(err_orphan), 64'(1));
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("orphan_cleared", 64'(err_orphan), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
